hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush/forward sequencer for the 5-stage pipeline.
- Drives the enable and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves load-use hazards, taken-branch/jump flushes and multi-cycle execute operations (e.g. divider) with a handshake.
- Generates ALU operand forwarding selects and keeps a saturating stall-cycle performance counter plus a sticky multi-cycle timeout flag.

Parameters:
- WIDTH, 32, width of the stall performance counter.
- MC_TIMEOUT, 64, maximum cycles spent in MC_WAIT before forced release.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Rs1_D  in  5  decode-stage source register 1.
- Rs2_D  in  5  decode-stage source register 2.
- Rs1_E  in  5  execute-stage source register 1.
- Rs2_E  in  5  execute-stage source register 2.
- Rd_E  in  5  execute-stage destination.
- RegWrite_E  in  1  execute-stage writes register.
- ResultSrc_E  in  2  execute-stage result select; 2'b01 = load.
- PCtaken_E  in  1  branch/jump resolved taken in execute.
- mc_start_E  in  1  instruction in execute is multi-cycle.
- mc_done  in  1  multi-cycle unit result valid this cycle.
- Rd_M  in  5  memory-stage destination.
- RegWrite_M  in  1  memory-stage writes register.
- Rd_W  in  5  writeback-stage destination.
- RegWrite_W  in  1  writeback-stage writes register.
- Stall_F  out  1  hold PC.
- Stall_D  out  1  hold IF/ID.
- Flush_D  out  1  clear IF/ID to bubble.
- Stall_E  out  1  hold ID/EX.
- Flush_E  out  1  clear ID/EX to bubble (RegWrite/MemWrite/PCsrc zeroed).
- Flush_M  out  1  clear EX/MEM to bubble.
- ForwardA_E  out  2  operand A select: 00 RD1_E, 10 ALU result from M, 01 result from W.
- ForwardB_E  out  2  operand B select, same encoding.
- stall_count  out  WIDTH  cycles with Stall_D=1, saturating at all-ones.
- mc_timeout  out  1  sticky: MC_WAIT exceeded MC_TIMEOUT.

Behaviour:
- Reset:
  - State RUN, mc cycle counter 0, stall_count 0, mc_timeout 0.
  - While rst_n=0, all stall, flush and forward outputs are 0.
- FSM states: RUN, MC_WAIT. All control outputs are Mealy, combinational from state and inputs, with zero latency.
- RUN:
  - Load-use: ResultSrc_E==01, RegWrite_E, Rd_E!=0, and Rd_E matches Rs1_D or Rs2_D → Stall_F=Stall_D=Flush_E=1 for that cycle only.
  - Taken branch: PCtaken_E → Flush_D=Flush_E=1.
  - Priority: a taken branch overrides load-use in the same cycle: stalls 0, both flushes 1.
  - Multi-cycle start: mc_start_E=1 and mc_done=0 → Stall_F=Stall_D=Stall_E=Flush_M=1; next state MC_WAIT; counter cleared to 0.
  - mc_start_E with mc_done=1 in the same cycle (single-cycle completion) → no stall, stay in RUN.
- MC_WAIT:
  - mc_done=0 → Stall_F=Stall_D=Stall_E=Flush_M=1; counter increments.
  - mc_done=1 → all stalls and flushes 0 (result captured by EX/MEM this edge); next state RUN.
  - Counter reaching MC_TIMEOUT-1 with mc_done=0 → mc_timeout set (sticky until reset); next state RUN; stalls released.
  - Load-use and PCtaken_E are ignored in MC_WAIT.
- Forwarding, evaluated independently per operand:
  - Select 10 if RegWrite_M, Rd_M!=0 and Rd_M==Rs1_E (Rs2_E for B).
  - Otherwise select 01 on the equivalent writeback match.
  - Otherwise 00.
  - Memory stage has priority over writeback.
  - Register x0 is never forwarded.
- stall_count: increments on each rising edge where Stall_D=1; holds at 2^WIDTH-1.
- Asynchronous reset mid-MC_WAIT: immediate return to RUN; outputs 0 while rst_n is low.

Test Plan:
- Load-use: lw x5 in E (ResultSrc_E=01, Rd_E=5), Rs1_D=5 → Stall_F=Stall_D=Flush_E=1 for exactly 1 cycle; stall_count 0→1.
- Load-use with Rd_E=0, Rs1_D=0 → no stall. Same load in E with PCtaken_E=1 → Flush_D=Flush_E=1, Stall_D=0.
- Divider: mc_start_E=1, mc_done asserted on the 5th cycle → Stall_E=Flush_M=1 for 4 cycles, released in the done cycle; stall_count=4; state back to RUN.
- Timeout: MC_TIMEOUT=8, mc_done held 0 → mc_timeout=1 after 8 stalled cycles; stalls drop; flag persists through 20 further cycles.
- Forwarding: Rd_M=Rd_W=7, both RegWrite, Rs1_E=7 → ForwardA_E=10. Only W match → 01. Rd_M=0 with Rs2_E=0 → ForwardB_E=00.
- Reset asserted during MC_WAIT → all outputs 0 immediately; after release, a new mc_start_E re-enters MC_WAIT cleanly with the counter restarting at 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward sequencer for the 5-stage pipeline.
// Resolves load-use, taken-branch and multi-cycle execute hazards.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   Rs1_D, Rs2_D          decode-stage sources
//   Rs1_E, Rs2_E, Rd_E    execute-stage sources / destination
//   RegWrite_E            execute-stage writes register
//   ResultSrc_E           execute result select (2'b01 = load)
//   PCtaken_E             branch/jump taken in execute
//   mc_start_E, mc_done   multi-cycle execute handshake
//   Rd_M, RegWrite_M      memory-stage destination / write enable
//   Rd_W, RegWrite_W      writeback-stage destination / write enable
//   Stall_F, Stall_D      hold PC / hold IF/ID
//   Flush_D               clear IF/ID
//   Stall_E, Flush_E      hold / clear ID/EX
//   Flush_M               clear EX/MEM
//   ForwardA_E/B_E        operand select: 00 RF, 10 MEM, 01 WB
//   stall_count           saturating count of Stall_D cycles
//   mc_timeout            sticky multi-cycle timeout flag
module hazard_ctrl #(
   parameter int WIDTH      = 32,
   parameter int MC_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       Rs1_D,
   input  logic [4:0]       Rs2_D,
   input  logic [4:0]       Rs1_E,
   input  logic [4:0]       Rs2_E,
   input  logic [4:0]       Rd_E,
   input  logic             RegWrite_E,
   input  logic [1:0]       ResultSrc_E,
   input  logic             PCtaken_E,
   input  logic             mc_start_E,
   input  logic             mc_done,
   input  logic [4:0]       Rd_M,
   input  logic             RegWrite_M,
   input  logic [4:0]       Rd_W,
   input  logic             RegWrite_W,
   output logic             Stall_F,
   output logic             Stall_D,
   output logic             Flush_D,
   output logic             Stall_E,
   output logic             Flush_E,
   output logic             Flush_M,
   output logic [1:0]       ForwardA_E,
   output logic [1:0]       ForwardB_E,
   output logic [WIDTH-1:0] stall_count,
   output logic             mc_timeout
);

   localparam int CW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MC_TIMEOUT - 1);

   localparam logic [0:0] RUN     = 1'b0;
   localparam logic [0:0] MC_WAIT = 1'b1;

   logic [0:0]       state_q;
   logic [0:0]       state_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             timeout_q;
   logic             timeout_d;
   logic [WIDTH-1:0] sc_q;

   logic             load_use;
   logic             mc_hold;
   logic             cnt_last;

   logic             sf;
   logic             sd;
   logic             fd;
   logic             se;
   logic             fe;
   logic             fm;
   logic [1:0]       fa;
   logic [1:0]       fb;

   assign load_use = (ResultSrc_E == 2'b01) && RegWrite_E &&
                     (Rd_E != 5'd0) &&
                     ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

   assign mc_hold  = mc_start_E && !mc_done;
   assign cnt_last = (cnt_q == CNT_LAST);

   always_comb begin
      sf        = 1'b0;
      sd        = 1'b0;
      fd        = 1'b0;
      se        = 1'b0;
      fe        = 1'b0;
      fm        = 1'b0;
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      case (state_q)
         RUN: begin
            // A taken branch squashes whatever is younger, so it
            // wins over any stall request raised in the same cycle.
            if (PCtaken_E) begin
               fd = 1'b1;
               fe = 1'b1;
            end else if (mc_hold) begin
               sf      = 1'b1;
               sd      = 1'b1;
               se      = 1'b1;
               fm      = 1'b1;
               state_d = MC_WAIT;
               cnt_d   = '0;
            end else if (load_use) begin
               sf = 1'b1;
               sd = 1'b1;
               fe = 1'b1;
            end
         end
         MC_WAIT: begin
            if (mc_done) begin
               state_d = RUN;
            end else if (cnt_last) begin
               // Give up on the unit: release the pipe, flag it.
               timeout_d = 1'b1;
               state_d   = RUN;
            end else begin
               sf    = 1'b1;
               sd    = 1'b1;
               se    = 1'b1;
               fm    = 1'b1;
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // MEM result is newer than WB, so it takes priority.
   assign fa = (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == Rs1_E)) ? 2'b10 :
               (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs1_E)) ? 2'b01 :
               2'b00;

   assign fb = (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == Rs2_E)) ? 2'b10 :
               (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs2_E)) ? 2'b01 :
               2'b00;

   // Controls are forced quiet for as long as reset is held.
   assign Stall_F    = rst_n & sf;
   assign Stall_D    = rst_n & sd;
   assign Flush_D    = rst_n & fd;
   assign Stall_E    = rst_n & se;
   assign Flush_E    = rst_n & fe;
   assign Flush_M    = rst_n & fm;
   assign ForwardA_E = {2{rst_n}} & fa;
   assign ForwardB_E = {2{rst_n}} & fb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sc_q <= '0;
      end else if (Stall_D && (sc_q != '1)) begin
         sc_q <= sc_q + WIDTH'(1);
      end
   end

   assign stall_count = sc_q;
   assign mc_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors and sequences for hazard_ctrl.
// Small WIDTH/MC_TIMEOUT so saturation and timeout are reachable.
module tb_hazard_ctrl;

   localparam int W  = 4;
   localparam int TO = 8;

   // {Stall_F,Stall_D,Flush_D,Stall_E,Flush_E,Flush_M,FA[1:0],FB[1:0]}
   localparam logic [9:0] NONE = 10'b0000000000;
   localparam logic [9:0] LU   = 10'b1100100000;
   localparam logic [9:0] BR   = 10'b0010100000;
   localparam logic [9:0] MC   = 10'b1101010000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic [4:0]   Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
   logic         RegWrite_E, RegWrite_M, RegWrite_W;
   logic [1:0]   ResultSrc_E;
   logic         PCtaken_E, mc_start_E, mc_done;
   logic         Stall_F, Stall_D, Flush_D, Stall_E, Flush_E, Flush_M;
   logic [1:0]   ForwardA_E, ForwardB_E;
   logic [W-1:0] stall_count;
   logic         mc_timeout;
   logic [9:0]   obs;

   hazard_ctrl #(
      .WIDTH(W),
      .MC_TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .Rs1_D(Rs1_D),
      .Rs2_D(Rs2_D),
      .Rs1_E(Rs1_E),
      .Rs2_E(Rs2_E),
      .Rd_E(Rd_E),
      .RegWrite_E(RegWrite_E),
      .ResultSrc_E(ResultSrc_E),
      .PCtaken_E(PCtaken_E),
      .mc_start_E(mc_start_E),
      .mc_done(mc_done),
      .Rd_M(Rd_M),
      .RegWrite_M(RegWrite_M),
      .Rd_W(Rd_W),
      .RegWrite_W(RegWrite_W),
      .Stall_F(Stall_F),
      .Stall_D(Stall_D),
      .Flush_D(Flush_D),
      .Stall_E(Stall_E),
      .Flush_E(Flush_E),
      .Flush_M(Flush_M),
      .ForwardA_E(ForwardA_E),
      .ForwardB_E(ForwardB_E),
      .stall_count(stall_count),
      .mc_timeout(mc_timeout)
   );

   assign obs = {Stall_F, Stall_D, Flush_D, Stall_E, Flush_E, Flush_M,
                 ForwardA_E, ForwardB_E};

   typedef struct {
      logic [4:0] rs1d, rs2d, rde;
      logic       rwe;
      logic [1:0] rse;
      logic       pct;
      logic [4:0] rs1e, rs2e, rdm;
      logic       rwm;
      logic [4:0] rdw;
      logic       rww;
      logic [9:0] exp;
   } vec_t;

   vec_t         vt[13];
   int           errors = 0;
   int           checks = 0;
   logic [W-1:0] exp_sc;

   function automatic vec_t mk(
      input int a, input int b, input int c, input int d,
      input int e, input int f, input int g, input int h,
      input int i, input int j, input int k, input int l,
      input logic [9:0] x);
      vec_t v;
      v.rs1d = 5'(a);
      v.rs2d = 5'(b);
      v.rde  = 5'(c);
      v.rwe  = 1'(d);
      v.rse  = 2'(e);
      v.pct  = 1'(f);
      v.rs1e = 5'(g);
      v.rs2e = 5'(h);
      v.rdm  = 5'(i);
      v.rwm  = 1'(j);
      v.rdw  = 5'(k);
      v.rww  = 1'(l);
      v.exp  = x;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0;
      Rd_E = 0; Rd_M = 0; Rd_W = 0;
      RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0;
      ResultSrc_E = 0; PCtaken_E = 0;
      mc_start_E = 0; mc_done = 0;
   endtask

   // Check outputs mid-cycle, then advance one edge and update the
   // expected saturating stall count.
   task automatic step(input string name, input logic [9:0] e);
      @(negedge clk);
      chk(name, 32'(obs), 32'(e));
      chk({name, "_sc"}, 32'(stall_count), 32'(exp_sc));
      @(posedge clk);
      if (e[8] && (exp_sc != '1)) exp_sc = exp_sc + 1'b1;
      #1;
   endtask

   task automatic mc_run(input string name, input int nstall,
                         input logic done);
      for (int i = 0; i < nstall; i++) begin
         idle();
         mc_start_E = (i == 0);
         if (i > 0) begin
            PCtaken_E = 1; Rs1_D = 5; Rd_E = 5;
            RegWrite_E = 1; ResultSrc_E = 2'b01;
         end
         step($sformatf("%s_stall%0d", name, i), MC);
      end
      idle();
      mc_done = done;
      step({name, "_release"}, NONE);
      idle();
      PCtaken_E = 1;
      step({name, "_run"}, BR);
   endtask

   initial begin
      vt[0]  = mk(5,0,5,1,1,0, 0,0,0,0,0,0, LU);
      vt[1]  = mk(3,5,5,1,1,0, 0,0,0,0,0,0, LU);
      vt[2]  = mk(0,0,0,1,1,0, 0,0,0,0,0,0, NONE);
      vt[3]  = mk(5,0,5,0,1,0, 0,0,0,0,0,0, NONE);
      vt[4]  = mk(5,0,5,1,0,0, 0,0,0,0,0,0, NONE);
      vt[5]  = mk(5,0,5,1,1,1, 0,0,0,0,0,0, BR);
      vt[6]  = mk(0,0,0,0,0,1, 0,0,0,0,0,0, BR);
      vt[7]  = mk(0,0,0,0,0,0, 7,0,7,1,7,1, 10'b0000001000);
      vt[8]  = mk(0,0,0,0,0,0, 7,0,3,1,7,1, 10'b0000000100);
      vt[9]  = mk(0,0,0,0,0,0, 0,0,0,1,0,1, NONE);
      vt[10] = mk(0,0,0,0,0,0, 9,0,9,0,9,1, 10'b0000000100);
      vt[11] = mk(0,0,0,0,0,0, 4,6,6,1,4,1, 10'b0000000110);
      vt[12] = mk(8,0,8,1,1,0, 2,0,2,1,0,0, 10'b1100101000);

      idle();
      rst_n  = 1'b0;
      exp_sc = '0;
      repeat (2) @(posedge clk);
      #1;
      Rs1_D = 5; Rd_E = 5; RegWrite_E = 1; ResultSrc_E = 2'b01;
      Rs1_E = 7; Rd_M = 7; RegWrite_M = 1; PCtaken_E = 1;
      #1;
      chk("reset_outs", 32'(obs), 32'(NONE));
      chk("reset_sc", 32'(stall_count), 32'd0);
      chk("reset_to", 32'(mc_timeout), 32'd0);
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      Rs1_D = 5; Rd_E = 5; RegWrite_E = 1; ResultSrc_E = 2'b01;
      step("lu_stall", LU);
      ResultSrc_E = 0; RegWrite_E = 0; Rd_E = 0;
      step("lu_release", NONE);
      chk("lu_sc_one", 32'(stall_count), 32'd1);

      for (int i = 0; i < 13; i++) begin
         idle();
         Rs1_D = vt[i].rs1d; Rs2_D = vt[i].rs2d; Rd_E = vt[i].rde;
         RegWrite_E = vt[i].rwe; ResultSrc_E = vt[i].rse;
         PCtaken_E = vt[i].pct;
         Rs1_E = vt[i].rs1e; Rs2_E = vt[i].rs2e;
         Rd_M = vt[i].rdm; RegWrite_M = vt[i].rwm;
         Rd_W = vt[i].rdw; RegWrite_W = vt[i].rww;
         step($sformatf("vec%0d", i), vt[i].exp);
      end

      idle();
      mc_start_E = 1; mc_done = 1;
      step("mc_single", NONE);
      idle();
      PCtaken_E = 1;
      step("mc_single_run", BR);

      mc_run("div", 4, 1'b1);
      chk("div_sc", 32'(stall_count), 32'd8);
      chk("div_to", 32'(mc_timeout), 32'd0);

      mc_run("to", 8, 1'b0);
      chk("to_flag", 32'(mc_timeout), 32'd1);
      chk("to_sat", 32'(stall_count), 32'd15);
      for (int i = 0; i < 20; i++) begin
         idle();
         step("to_hold", NONE);
         chk("to_sticky", 32'(mc_timeout), 32'd1);
      end

      mc_run("sat", 3, 1'b1);
      chk("sat_hold", 32'(stall_count), 32'd15);

      idle();
      mc_start_E = 1;
      step("rst_mc0", MC);
      idle();
      step("rst_mc1", MC);
      Rs1_E = 7; Rd_M = 7; RegWrite_M = 1;
      #2;
      rst_n = 1'b0;
      exp_sc = '0;
      #1;
      chk("rst_mid_outs", 32'(obs), 32'(NONE));
      chk("rst_mid_sc", 32'(stall_count), 32'd0);
      chk("rst_mid_to", 32'(mc_timeout), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_hold_outs", 32'(obs), 32'(NONE));
      idle();
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step("rst_after", NONE);
      mc_run("rst_to", 8, 1'b0);
      chk("rst_to_flag", 32'(mc_timeout), 32'd1);
      chk("rst_to_sc", 32'(stall_count), 32'd8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
